// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric FIR: one shared multiplier folds the tap pairs
// x[k] + x[2N-1-k] and accumulates HALF_TAPS products per accepted sample.
module fir_sym_mc #(
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int HALF_TAPS = 11,
    parameter int CHANNELS  = 2,
    parameter int OUT_W     = 20,
    parameter int SHIFT     = 0,
    parameter logic [HALF_TAPS-1:0][COEF_W-1:0] COEF_INIT = {
        8'd128, 8'd122, 8'd111, 8'd95, 8'd78, 8'd60,
        8'd43,  8'd28,  8'd16,  8'd10, 8'd2
    },
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int K_W  = (HALF_TAPS > 1) ? $clog2(HALF_TAPS) : 1
) (
    input  logic              CLK_Filter,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              coef_we,
    input  logic [K_W-1:0]    coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  out_data
);

    localparam int TAPS   = 2 * HALF_TAPS;
    localparam int T_W    = $clog2(TAPS);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = COEF_W + PRE_W;
    localparam int ACC_W  = DATA_W + 1 + COEF_W + K_W;
    localparam int SAT_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(HALF_TAPS - 1);
    localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(CHANNELS - 1);
    localparam logic [T_W-1:0]   IDX_TOP  = T_W'(TAPS - 1);
    localparam logic [SAT_W-1:0] SAT_MAX  = SAT_W'({OUT_W{1'b1}});

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] x_q [CHANNELS][TAPS];
    logic [DATA_W-1:0] x_d [CHANNELS][TAPS];
    logic [COEF_W-1:0] coef_q [HALF_TAPS];
    logic [COEF_W-1:0] coef_d [HALF_TAPS];
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;

    logic [T_W-1:0]    idx_lo, idx_hi;
    logic [PRE_W-1:0]  pre_add;
    logic [PROD_W-1:0] product;
    logic [ACC_W-1:0]  acc_sum;
    logic [SAT_W-1:0]  shifted;
    logic [OUT_W-1:0]  sat_val;

    // Shared MAC datapath: the step counter picks the mirrored tap pair.
    always_comb begin
        idx_lo  = T_W'(k_q);
        idx_hi  = IDX_TOP - idx_lo;
        pre_add = PRE_W'(x_q[ch_q][idx_lo]) + PRE_W'(x_q[ch_q][idx_hi]);
        product = PROD_W'(coef_q[k_q]) * PROD_W'(pre_add);
        acc_sum = acc_q + ACC_W'(product);
        shifted = SAT_W'(acc_sum >> SHIFT);
        sat_val = (shifted > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : shifted[OUT_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        coef_d     = coef_q;
        acc_d      = acc_q;
        k_d        = k_q;
        ch_d       = ch_q;
        out_ch_d   = out_ch_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (coef_we && (coef_addr <= K_LAST)) begin
                    coef_d[coef_addr] = coef_data;
                end
                // Out-of-range channels are consumed here without touching any line.
                if (in_valid && (in_ch <= CH_MAX)) begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (CH_W'(c) == in_ch) begin
                            x_d[c][0] = in_data;
                            for (int i = 1; i < TAPS; i++) begin
                                x_d[c][i] = x_q[c][i-1];
                            end
                        end
                    end
                    acc_d   = '0;
                    k_d     = '0;
                    ch_d    = in_ch;
                    state_d = S_MAC;
                end
            end

            S_MAC: begin
                acc_d = acc_sum;
                k_d   = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d        = '0;
                    out_data_d = sat_val;
                    out_ch_d   = ch_q;
                    state_d    = S_OUT;
                end
            end

            S_OUT: begin
                out_valid = 1'b1;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_Filter) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            k_q        <= '0;
            ch_q       <= '0;
            out_ch_q   <= '0;
            out_data_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int i = 0; i < TAPS; i++) begin
                    x_q[c][i] <= '0;
                end
            end
            for (int i = 0; i < HALF_TAPS; i++) begin
                coef_q[i] <= COEF_INIT[i];
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            ch_q       <= ch_d;
            out_ch_q   <= out_ch_d;
            out_data_q <= out_data_d;
            x_q        <= x_d;
            coef_q     <= coef_d;
        end
    end

    assign out_ch   = out_ch_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_fir_sym_mc.sv
// Directed bench for fir_sym_mc: impulse, DC, timing, coefficient writes,
// mid-computation reset and a saturating instance with an invalid channel.
module tb_fir_sym_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready;
    logic [0:0]  in_ch;
    logic [7:0]  in_data;
    logic        coef_we;
    logic [3:0]  coef_addr;
    logic [7:0]  coef_data;
    logic        out_valid;
    logic [0:0]  out_ch;
    logic [19:0] out_data;

    logic        s_in_valid, s_in_ready;
    logic [1:0]  s_in_ch;
    logic [7:0]  s_in_data;
    logic        s_coef_we;
    logic [3:0]  s_coef_addr;
    logic [7:0]  s_coef_data;
    logic        s_out_valid;
    logic [1:0]  s_out_ch;
    logic [15:0] s_out_data;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;

    int imp [23] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128,
                     128, 122, 111, 95, 78, 60, 43, 28, 16, 10, 2, 0};

    fir_sym_mc u_dut (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_data   (out_data)
    );

    fir_sym_mc #(.OUT_W(16), .CHANNELS(3)) u_sat (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_ch      (s_in_ch),
        .in_data    (s_in_data),
        .coef_we    (s_coef_we),
        .coef_addr  (s_coef_addr),
        .coef_data  (s_coef_data),
        .out_valid  (s_out_valid),
        .out_ch     (s_out_ch),
        .out_data   (s_out_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        chk_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Offers one sample (optionally with a coincident coefficient write, and
    // optionally a write attempt during MAC) and captures the result strobe.
    task automatic applyStimulus(input logic ch, input logic [7:0] data,
                                 input logic idle_we, input logic [7:0] idle_val,
                                 input logic mac_we,
                                 output logic seen, output int od, output int oc,
                                 output int lat, output logic ready_low,
                                 output logic after_ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b1;
        in_ch     = ch;
        in_data   = data;
        coef_we   = idle_we;
        coef_addr = 4'd10;
        coef_data = idle_val;
        seen = 1'b0; od = 0; oc = 0; lat = 0; ready_low = 1'b1; after_ok = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                in_valid = 1'b0;
                coef_we  = 1'b0;
            end
            if (mac_we && i == 4) begin
                coef_we   = 1'b1;
                coef_addr = 4'd10;
                coef_data = 8'd0;
            end
            if (mac_we && i == 5) coef_we = 1'b0;
            if (in_ready) ready_low = 1'b0;
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
                od   = out_data;
                oc   = out_ch;
                break;
            end
        end
        if (seen) begin
            @(negedge clk);
            after_ok = in_ready && !out_valid;
        end
    endtask

    task automatic satStimulus(input logic [1:0] ch, input logic [7:0] data,
                               output logic seen, output int od, output int oc,
                               output logic ready_n1);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        s_in_valid = 1'b1;
        s_in_ch    = ch;
        s_in_data  = data;
        seen = 1'b0; od = 0; oc = 0; ready_n1 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                s_in_valid = 1'b0;
                ready_n1   = s_in_ready;
            end
            if (s_out_valid) begin
                seen = 1'b1;
                od   = s_out_data;
                oc   = s_out_ch;
                break;
            end
        end
        if (seen) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic seen, ready_low, after_ok, ready_n1, any_valid;
        int od, oc, lat, dc_sum, expv;

        rst_n = 1'b0;
        in_valid = 1'b0; in_ch = '0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        s_in_valid = 1'b0; s_in_ch = '0; s_in_data = '0;
        s_coef_we = 1'b0; s_coef_addr = '0; s_coef_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_ch", out_ch, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_sat_out_data", s_out_data, 0);
        rst_n = 1'b1;

        // Impulse on ch0 interleaved with DC 255 on ch1
        dc_sum = 0;
        for (int n = 0; n < 22; n++) begin
            applyStimulus(1'b0, (n == 0) ? 8'd1 : 8'd0, 1'b0, 8'd0, 1'b0,
                          seen, od, oc, lat, ready_low, after_ok);
            checkOutput($sformatf("imp%0d", n), od, imp[n]);
            if (n == 0) begin
                checkOutput("lat_first", lat, 12);
                checkOutput("ready_low_busy", ready_low, 1);
                checkOutput("ready_after_out", after_ok, 1);
                checkOutput("ch0_out_ch", oc, 0);
            end
            dc_sum = dc_sum + 255 * imp[n];
            applyStimulus(1'b1, 8'd255, 1'b0, 8'd0, 1'b0,
                          seen, od, oc, lat, ready_low, after_ok);
            if (n == 0 || n == 10 || n == 21) begin
                checkOutput($sformatf("dc%0d", n), od, dc_sum);
                checkOutput($sformatf("dc%0d_ch", n), oc, 1);
                checkOutput($sformatf("dc%0d_lat", n), lat, 12);
            end
        end
        checkOutput("dc_final_const", dc_sum, 353430);
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, seen, od, oc, lat, ready_low, after_ok);
        checkOutput("imp_flush", od, imp[22]);
        checkOutput("imp_flush_seen", seen, 1);

        // coef[10]=0 written in IDLE together with the first impulse sample
        for (int n = 0; n < 23; n++) begin
            applyStimulus(1'b0, (n == 0) ? 8'd1 : 8'd0, (n == 0), 8'd0, 1'b0,
                          seen, od, oc, lat, ready_low, after_ok);
            expv = (n == 10 || n == 11) ? 0 : imp[n];
            checkOutput($sformatf("c10zero_%0d", n), od, expv);
        end

        // Restore coef[10]=128 coincident with acceptance; MAC-time writes ignored
        for (int n = 0; n < 23; n++) begin
            applyStimulus(1'b0, (n == 0) ? 8'd1 : 8'd0, (n == 0), 8'd128, 1'b1,
                          seen, od, oc, lat, ready_low, after_ok);
            checkOutput($sformatf("macwe_%0d", n), od, imp[n]);
        end

        // Reset mid-MAC after corrupting coef[10]
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd0, 1'b0, seen, od, oc, lat, ready_low, after_ok);
        checkOutput("pre_rst_zero", od, 0);
        @(negedge clk);
        in_valid = 1'b1; in_ch = 1'b0; in_data = 8'd5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) any_valid = 1'b1;
        end
        checkOutput("rst_mac_no_valid", any_valid, 0);
        checkOutput("rst_mac_out_data", out_data, 0);
        checkOutput("rst_mac_in_ready", in_ready, 1);
        for (int n = 0; n < 23; n++) begin
            applyStimulus(1'b0, (n == 0) ? 8'd1 : 8'd0, 1'b0, 8'd0, 1'b0,
                          seen, od, oc, lat, ready_low, after_ok);
            checkOutput($sformatf("postrst_%0d", n), od, imp[n]);
        end

        // Saturating instance: DC 255 on ch0, then an invalid channel
        dc_sum = 0;
        for (int n = 0; n < 22; n++) begin
            satStimulus(2'd0, 8'd255, seen, od, oc, ready_n1);
            dc_sum = dc_sum + 255 * imp[n];
            expv = (dc_sum > 65535) ? 65535 : dc_sum;
            checkOutput($sformatf("sat%0d", n), od, expv);
        end
        satStimulus(2'd3, 8'd255, seen, od, oc, ready_n1);
        checkOutput("badch_no_out", seen, 0);
        checkOutput("badch_ready", ready_n1, 1);
        checkOutput("badch_hold", s_out_data, 65535);
        satStimulus(2'd2, 8'd255, seen, od, oc, ready_n1);
        checkOutput("ch2_first", od, 510);
        checkOutput("ch2_out_ch", oc, 2);
        checkOutput("ch2_busy", ready_n1, 0);
        satStimulus(2'd0, 8'd255, seen, od, oc, ready_n1);
        checkOutput("ch0_after_bad", od, 65535);
        checkOutput("ch0_after_bad_ch", oc, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fir_sym_mc.md
FIR_SYM_MC -- requirements
Module: fir_sym_mc

Interface
REQ-001 Parameter DATA_W, default 8, meaning unsigned input sample width.
REQ-002 Parameter COEF_W, default 8, meaning unsigned coefficient width.
REQ-003 Parameter HALF_TAPS, default 11, meaning unique coefficients; filter length is 2*HALF_TAPS taps with symmetric coefficients.
REQ-004 Parameter CHANNELS, default 2, meaning independent delay lines (ch0 = IR, ch1 = red).
REQ-005 Parameter OUT_W, default 20, meaning output width.
REQ-006 Parameter SHIFT, default 0, meaning right shift applied to the accumulator before saturation.
REQ-007 Parameter COEF_INIT, default {128,122,111,95,78,60,43,28,16,10,2} (index 10 down to 0), meaning reset value of the coefficient table.
REQ-008 CLK_Filter  input  1  sole clock, rising edge.
REQ-009 rst_n  input  1  synchronous active-low reset.
REQ-010 in_valid  input  1  sample offered.
REQ-011 in_ready  output  1  block can accept a sample.
REQ-012 in_ch  input  clog2(CHANNELS)  channel of the offered sample.
REQ-013 in_data  input  DATA_W  sample value.
REQ-014 coef_we  input  1  coefficient write strobe.
REQ-015 coef_addr  input  clog2(HALF_TAPS)  coefficient index.
REQ-016 coef_data  input  COEF_W  coefficient value.
REQ-017 out_valid  output  1  single-cycle result strobe.
REQ-018 out_ch  output  clog2(CHANNELS)  channel of the result.
REQ-019 out_data  output  OUT_W  filtered result.

Function
REQ-020 The block SHALL be a three-state FSM: IDLE, MAC, OUT.
REQ-021 in_ready SHALL be 1 only in IDLE; a sample is accepted on a cycle with in_valid && in_ready.
REQ-022 On acceptance, the block SHALL shift in_data into x[in_ch][0], move x[in_ch][i] to x[in_ch][i+1], drop the oldest sample, clear the accumulator, latch in_ch, and enter MAC; other channels' lines SHALL be unchanged.
REQ-023 An in_ch value >= CHANNELS SHALL be accepted and discarded with no state change and no output; the FSM SHALL stay in IDLE.
REQ-024 MAC SHALL last exactly HALF_TAPS cycles; at step k (0..HALF_TAPS-1) acc += coef[k] * (x[ch][k] + x[ch][2*HALF_TAPS-1-k]), with one multiplier.
REQ-025 The pre-add SHALL be DATA_W+1 bits and the accumulator DATA_W+1+COEF_W+clog2(HALF_TAPS) bits; it SHALL never overflow.
REQ-026 OUT SHALL last one cycle: out_valid=1, out_ch=latched channel, out_data=min(acc>>SHIFT, 2^OUT_W-1); then return to IDLE.
REQ-027 Latency SHALL be HALF_TAPS+1 cycles from the acceptance edge to out_valid; throughput SHALL be one sample per HALF_TAPS+2 cycles.
REQ-028 out_data and out_ch SHALL hold their values until the next OUT; out_valid SHALL be 0 outside OUT.
REQ-029 coef_we in IDLE SHALL write coef[coef_addr]=coef_data at that edge; coef_addr >= HALF_TAPS SHALL be ignored.
REQ-030 coef_we in MAC or OUT SHALL be ignored (no queuing), so one result never mixes old and new coefficients.
REQ-031 If coef_we and an accepted sample coincide in IDLE, the write SHALL take effect and the MAC for that sample SHALL use the new value.

Reset
REQ-032 With rst_n=0 at a clock edge, the block SHALL clear all delay lines and the accumulator, load coef from COEF_INIT, set state IDLE, and drive out_valid=0, out_ch=0, out_data=0, in_ready=1 from the next cycle.
REQ-033 Reset asserted in MAC or OUT SHALL abort the computation with no out_valid pulse.

Verification
REQ-034 Impulse: defaults; ch0 gets 1 then 21 zeros -> ch0 out_data sequence 2,10,16,28,43,60,78,95,111,122,128,128,122,...,2, then 0.
REQ-035 DC: ch1 fed 255 for 22 samples -> 22nd out_data = 353430; ch0 outputs meanwhile unaffected (ch0 impulse interleaved gives REQ-034 sequence).
REQ-036 Timing: accept at edge T -> out_valid exactly at T+12, in_ready low T+1..T+12, next accept no earlier than T+13.
REQ-037 Coef write coef[10]=0 in IDLE, then ch0 impulse -> 11th and 12th outputs 0; the same write issued during MAC -> ignored, outputs unchanged.
REQ-038 Reset mid-MAC -> no out_valid, out_data=0, coef back to COEF_INIT, next impulse matches REQ-034.
REQ-039 Saturation: OUT_W=16, SHIFT=0, DC 255 -> out_data = 65535; in_ch=3 offered -> accepted, no output.
